// File: rtl/deinterleaver_pkg.sv
// Shared 802.11a interleaver constants and index arithmetic for the RX deinterleaver.
// The TX interleaver uses the same rate table and s_of() helper.
package deinterleaver_pkg;

  // Read-side drain controller states.
  typedef enum logic {
    RD_IDLE  = 1'b0,
    RD_DRAIN = 1'b1
  } rd_state_t;

  // Coded bits per OFDM symbol and per subcarrier for each modulation.
  // BPSK covers 6/9 Mb/s, QPSK 12/18, 16-QAM 24/36 and 64-QAM 48/54.
  localparam int NCBPS_BPSK  = 48;
  localparam int NBPSC_BPSK  = 1;
  localparam int NCBPS_QPSK  = 96;
  localparam int NBPSC_QPSK  = 2;
  localparam int NCBPS_QAM16 = 192;
  localparam int NBPSC_QAM16 = 4;
  localparam int NCBPS_QAM64 = 288;
  localparam int NBPSC_QAM64 = 6;

  // Column-rotation span of the second permutation: max(Nbpsc/2, 1).
  function automatic int unsigned s_of(input int unsigned nbpsc);
    return (nbpsc / 2 > 1) ? nbpsc / 2 : 1;
  endfunction

  // Original coded position k of the bit received at position j.
  // Undoes the second (rotation) permutation first, then the row/column transpose.
  function automatic int unsigned deintlv_k(input int unsigned j,
                                            input int unsigned ncbps,
                                            input int unsigned nbpsc);
    int unsigned s;
    int unsigned i;
    s = s_of(nbpsc);
    i = s * (j / s) + ((j + (16 * j) / ncbps) % s);
    return 16 * i - (ncbps - 1) * ((16 * i) / ncbps);
  endfunction

  // True only for the four Ncbps/Nbpsc pairs the standard defines.
  function automatic bit rate_ok(input int unsigned ncbps, input int unsigned nbpsc);
    return ((ncbps == NCBPS_BPSK)  && (nbpsc == NBPSC_BPSK))  ||
           ((ncbps == NCBPS_QPSK)  && (nbpsc == NBPSC_QPSK))  ||
           ((ncbps == NCBPS_QAM16) && (nbpsc == NBPSC_QAM16)) ||
           ((ncbps == NCBPS_QAM64) && (nbpsc == NBPSC_QAM64));
  endfunction

endpackage

// File: rtl/deintlv_index_rom.sv
// Constant lookup of the deinterleaved write address k for each received position j.
// The table is evaluated entirely from constants, so no arithmetic exists at run time.
module deintlv_index_rom
  import deinterleaver_pkg::*;
#(
  parameter int Ncbps  = NCBPS_BPSK,
  parameter int Nbpsc  = NBPSC_BPSK,
  parameter int ADDR_W = 9
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [ADDR_W-1:0] k
);

  localparam int depth = 2 ** ADDR_W;

  // Padded to a power of two so the address indexes it exactly; the pad never gets addressed.
  logic [ADDR_W-1:0] rom_table [depth];

  for (genvar g = 0; g < depth; g++) begin : g_rom
    if (g < Ncbps) begin : g_used
      assign rom_table[g] = ADDR_W'(deintlv_k(g, Ncbps, Nbpsc));
    end else begin : g_pad
      assign rom_table[g] = '0;
    end
  end

  assign k = rom_table[addr];

endmodule

// File: rtl/deinterleaver.sv
// 802.11a receive block deinterleaver with ping-pong banks.
// One bank fills in received order while the other drains in original coded order.
module deinterleaver
  import deinterleaver_pkg::*;
#(
  parameter int Ncbps  = NCBPS_BPSK,
  parameter int Nbpsc  = NBPSC_BPSK,
  parameter int ADDR_W = 9
) (
  input  logic Clk,
  input  logic Reset,
  input  logic EN,
  input  logic Data,
  output logic Out,
  output logic Out_Valid,
  output logic Sym_Last
);

  localparam int                depth    = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] last_idx = ADDR_W'(Ncbps - 1);
  localparam bit                cfg_ok   = rate_ok(Ncbps, Nbpsc) && (depth >= Ncbps);

  logic [ADDR_W-1:0] wr_cnt;
  logic [ADDR_W-1:0] wr_k;
  logic              wr_bank;
  logic              write_done;

  logic [ADDR_W-1:0] rd_cnt;
  logic [ADDR_W-1:0] next_rd_cnt;
  logic              rd_bank;
  logic              next_rd_bank;
  logic              read_go;
  logic              read_sel;
  logic              other_sel;
  logic              drain_done;
  logic              oldest;

  logic [1:0]        bank_full;
  logic [1:0]        next_bank_full;

  // Bank storage is sized to the address space; only the first Ncbps bits are ever touched.
  logic [depth-1:0]  bank_mem [2];

  rd_state_t         state;
  rd_state_t         next_state;

  deintlv_index_rom #(
    .Ncbps  (Ncbps),
    .Nbpsc  (Nbpsc),
    .ADDR_W (ADDR_W)
  ) u_index_rom (
    .addr (wr_cnt),
    .k    (wr_k)
  );

  assign write_done = EN && (wr_cnt == last_idx);

  // Write position counter and fill-bank selector; a reset discards any partial symbol.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      wr_cnt  <= '0;
      wr_bank <= 1'b0;
    end else if (EN) begin
      if (wr_cnt == last_idx) begin
        wr_cnt  <= '0;
        wr_bank <= ~wr_bank;
      end else begin
        wr_cnt <= wr_cnt + 1'b1;
      end
    end
  end

  // Scatter each received bit straight to its original coded position; contents survive reset.
  always_ff @(posedge Clk) begin
    if (EN) begin
      bank_mem[wr_bank][wr_k] <= Data;
    end
  end

  // Oldest full bank: the one filled first is the current fill target when both are full.
  always_comb begin
    oldest = 1'b0;
    case (bank_full)
      2'b01:   oldest = 1'b0;
      2'b10:   oldest = 1'b1;
      2'b11:   oldest = wr_bank;
      default: oldest = 1'b0;
    endcase
  end

  // Drain controller: the IDLE->DRAIN edge already emits k=0, giving one cycle of latency.
  always_comb begin
    next_state   = state;
    next_rd_bank = rd_bank;
    next_rd_cnt  = rd_cnt;
    read_go      = 1'b0;
    read_sel     = rd_bank;
    drain_done   = 1'b0;
    case (state)
      RD_IDLE: begin
        if (|bank_full) begin
          read_go  = 1'b1;
          read_sel = oldest;
        end
      end
      RD_DRAIN: begin
        read_go = 1'b1;
      end
      default: begin
        next_state = RD_IDLE;
      end
    endcase
    other_sel = ~read_sel;
    if (read_go) begin
      next_state   = RD_DRAIN;
      next_rd_bank = read_sel;
      if (rd_cnt == last_idx) begin
        drain_done  = 1'b1;
        next_rd_cnt = '0;
        if (bank_full[other_sel]) begin
          next_rd_bank = other_sel;
        end else begin
          next_state = RD_IDLE;
        end
      end else begin
        next_rd_cnt = rd_cnt + 1'b1;
      end
    end
  end

  // Full flags: a completed fill and a completed drain always target different banks.
  always_comb begin
    next_bank_full = bank_full;
    if (write_done) begin
      next_bank_full[wr_bank] = 1'b1;
    end
    if (drain_done) begin
      next_bank_full[read_sel] = 1'b0;
    end
  end

  // Read-side state register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= RD_IDLE;
      rd_cnt    <= '0;
      rd_bank   <= 1'b0;
      bank_full <= 2'b00;
    end else begin
      state     <= next_state;
      rd_cnt    <= next_rd_cnt;
      rd_bank   <= next_rd_bank;
      bank_full <= next_bank_full;
    end
  end

  // Registered bank read and output qualifiers; outputs idle at zero.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      Out       <= 1'b0;
      Out_Valid <= 1'b0;
      Sym_Last  <= 1'b0;
    end else begin
      Out       <= read_go ? bank_mem[read_sel][rd_cnt] : 1'b0;
      Out_Valid <= read_go;
      Sym_Last  <= read_go && (rd_cnt == last_idx);
    end
  end

  // Illegal rate parameters or a bank too small for one symbol.
  a_cfg : assert property (@(posedge Clk) cfg_ok);

  // A new bit must never land in a bank that is still waiting to drain.
  a_no_overflow : assert property (@(posedge Clk) disable iff (Reset) EN |-> !bank_full[wr_bank]);

endmodule

// File: tb/tb_deinterleaver.sv
// Self-checking bench for deinterleaver, one instance per 802.11a modulation.
// The reference is the forward TX interleaver: coded bits are interleaved by
// formula, fed in, and must come back in original order.
module tb_deinterleaver;

  localparam int ND      = 4;
  localparam int NC [ND] = '{48, 96, 192, 288};
  localparam int NB [ND] = '{1, 2, 4, 6};
  localparam int TIMEOUT = 2000;
  localparam int NVEC    = 11;

  typedef struct {
    int dut;
    int one_j;
    int exp_k;
  } vec_t;

  logic Clk   = 1'b0;
  logic Reset = 1'b1;
  logic en    [ND];
  logic din   [ND];
  logic dout  [ND];
  logic dval  [ND];
  logic dlast [ND];

  int checks   = 0;
  int errors   = 0;
  int edge_n   = 0;
  int mon_sel  = 0;
  bit mon_on   = 1'b0;
  int idle_bad = 0;
  int stray    = 0;

  bit got_bit  [$];
  bit got_last [$];
  int got_cyc  [$];

  // 100 MHz clock.
  always #5 Clk = ~Clk;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    deinterleaver #(
      .Ncbps  (NC[g]),
      .Nbpsc  (NB[g]),
      .ADDR_W (9)
    ) u_dut (
      .Clk       (Clk),
      .Reset     (Reset),
      .EN        (en[g]),
      .Data      (din[g]),
      .Out       (dout[g]),
      .Out_Valid (dval[g]),
      .Sym_Last  (dlast[g])
    );
  end

  // Count rising edges so output timing can be compared against input sample edges.
  always @(posedge Clk) edge_n <= edge_n + 1;

  // Capture valid output of the selected instance; flag nonzero idle outputs and any
  // valid output from instances that were given no input.
  always @(negedge Clk) begin
    if (mon_on) begin
      for (int d = 0; d < ND; d++) begin
        if (d == mon_sel) begin
          if (dval[d] === 1'b1) begin
            got_bit.push_back(dout[d]);
            got_last.push_back(dlast[d]);
            got_cyc.push_back(edge_n);
          end else if (dval[d] !== 1'b0 || dout[d] !== 1'b0 || dlast[d] !== 1'b0) begin
            idle_bad++;
          end
        end else if (dval[d] !== 1'b0) begin
          stray++;
        end
      end
    end
  end

  // Forward 802.11a interleaver: coded position k -> transmitted position j.
  function automatic int tx_j(input int nc, input int nb, input int k);
    int s;
    int i;
    s = (nb / 2 > 1) ? nb / 2 : 1;
    i = (nc / 16) * (k % 16) + k / 16;
    return s * (i / s) + (i + nc - (16 * i) / nc) % s;
  endfunction

  task automatic check(input string name, input int actual, input int required);
    checks++;
    if (actual != required) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, required);
    end
  endtask

  // Interleave whole symbols of coded bits b into transmit order x.
  task automatic interleave(input int d, input bit b[$], output bit x[$]);
    x = {};
    for (int i = 0; i < b.size(); i++) x.push_back(1'b0);
    for (int s = 0; s < b.size() / NC[d]; s++)
      for (int k = 0; k < NC[d]; k++)
        x[s * NC[d] + tx_j(NC[d], NB[d], k)] = b[s * NC[d] + k];
  endtask

  task automatic randomBits(input int n, output bit b[$]);
    b = {};
    for (int i = 0; i < n; i++) b.push_back(1'($urandom_range(0, 1)));
  endtask

  // Drive bits into instance d, EN high once every (gap+1) cycles; report each sample edge.
  task automatic applyStimulus(input int d, input bit x[$], input int gap, output int edges[$]);
    edges = {};
    for (int j = 0; j < x.size(); j++) begin
      @(negedge Clk);
      en[d]  = 1'b1;
      din[d] = x[j];
      edges.push_back(edge_n + 1);
      for (int g = 0; g < gap; g++) begin
        @(negedge Clk);
        en[d]  = 1'b0;
        din[d] = 1'b0;
      end
    end
    @(negedge Clk);
    en[d]  = 1'b0;
    din[d] = 1'b0;
  endtask

  // Wait (bounded) for n captured bits beyond base, then a few more cycles to catch extras.
  task automatic waitOutputs(input int base, input int n);
    int t;
    t = 0;
    while ((got_bit.size() - base) < n && t < TIMEOUT) begin
      @(negedge Clk);
      t++;
    end
    repeat (4) @(negedge Clk);
    #1;
  endtask

  task automatic doReset(input int cycles);
    @(negedge Clk);
    Reset = 1'b1;
    repeat (cycles) @(negedge Clk);
    Reset = 1'b0;
  endtask

  // Compare captured output from base against the expected coded bits and timing.
  task automatic checkOutput(input string tag, input int base, input bit exp_b[$], input int nc,
                             input int first_edge, input bit continuous);
    int n, lim, mism, lbad, contig_bad, gap_bad, nsym;
    n          = got_bit.size() - base;
    lim        = (n < exp_b.size()) ? n : exp_b.size();
    nsym       = exp_b.size() / nc;
    mism       = 0;
    lbad       = 0;
    contig_bad = 0;
    gap_bad    = 0;
    check({tag, " count"}, n, exp_b.size());
    for (int i = 0; i < lim; i++) if (got_bit[base + i] != exp_b[i]) mism++;
    check({tag, " data_mismatches"}, mism, 0);
    for (int i = 0; i < n; i++) if (got_last[base + i] != ((i % nc) == nc - 1)) lbad++;
    check({tag, " sym_last_errors"}, lbad, 0);
    check({tag, " first_edge"}, (n > 0) ? got_cyc[base] : -1, first_edge);
    for (int s = 0; s < nsym; s++) begin
      if ((s + 1) * nc <= n) begin
        if (got_cyc[base + (s + 1) * nc - 1] - got_cyc[base + s * nc] != nc - 1) contig_bad++;
        if (!continuous && s > 0 && got_cyc[base + s * nc] - got_cyc[base + s * nc - 1] <= 1)
          gap_bad++;
      end else begin
        contig_bad++;
      end
    end
    check({tag, " noncontiguous_symbols"}, contig_bad, 0);
    if (continuous && n == exp_b.size() && n > 0)
      check({tag, " total_span"}, got_cyc[base + n - 1] - got_cyc[base], n - 1);
    if (!continuous && nsym > 1)
      check({tag, " missing_idle_gaps"}, gap_bad, 0);
  endtask

  initial begin
    vec_t vecs [NVEC];
    bit   x [$];
    bit   b [$];
    int   edges [$];
    int   base, idle0, stray0, cnt, t;

    // Single-one vectors: instance, received position of the 1, coded position it must reach.
    vecs[0]  = '{0, 1,   16};
    vecs[1]  = '{0, 3,   1};
    vecs[2]  = '{0, 47,  47};
    vecs[3]  = '{1, 6,   1};
    vecs[4]  = '{1, 95,  95};
    vecs[5]  = '{2, 12,  17};
    vecs[6]  = '{2, 1,   16};
    vecs[7]  = '{2, 191, 175};
    vecs[8]  = '{3, 1,   16};
    vecs[9]  = '{3, 18,  17};
    vecs[10] = '{3, 287, 287};

    for (int d = 0; d < ND; d++) begin
      en[d]  = 1'b0;
      din[d] = 1'b0;
    end

    // Reset state on every instance.
    repeat (3) @(negedge Clk);
    for (int d = 0; d < ND; d++) begin
      check($sformatf("reset dut%0d out_valid_zero", d), int'(dval[d] === 1'b0), 1);
      check($sformatf("reset dut%0d out_zero", d), int'(dout[d] === 1'b0), 1);
      check($sformatf("reset dut%0d sym_last_zero", d), int'(dlast[d] === 1'b0), 1);
    end
    Reset  = 1'b0;
    mon_on = 1'b1;
    idle0  = idle_bad;
    stray0 = stray;

    // Table-driven single-one symbols.
    for (int v = 0; v < NVEC; v++) begin
      mon_sel = vecs[v].dut;
      x = {};
      b = {};
      for (int i = 0; i < NC[vecs[v].dut]; i++) begin
        x.push_back(i == vecs[v].one_j);
        b.push_back(i == vecs[v].exp_k);
      end
      base = got_bit.size();
      applyStimulus(vecs[v].dut, x, 0, edges);
      waitOutputs(base, NC[vecs[v].dut]);
      checkOutput($sformatf("vec%0d", v), base, b, NC[vecs[v].dut], edges[edges.size() - 1] + 1, 1'b1);
    end

    // Three back-to-back random symbols through the interleaver model, every rate.
    for (int d = 0; d < ND; d++) begin
      mon_sel = d;
      randomBits(3 * NC[d], b);
      interleave(d, b, x);
      base = got_bit.size();
      applyStimulus(d, x, 0, edges);
      waitOutputs(base, 3 * NC[d]);
      checkOutput($sformatf("chain dut%0d", d), base, b, NC[d], edges[NC[d] - 1] + 1, 1'b1);
    end

    // EN pulsed one cycle in three: each symbol drains contiguously, idle in between.
    mon_sel = 0;
    randomBits(2 * NC[0], b);
    interleave(0, b, x);
    base = got_bit.size();
    applyStimulus(0, x, 2, edges);
    waitOutputs(base, 2 * NC[0]);
    checkOutput("sparse_en", base, b, NC[0], edges[NC[0] - 1] + 1, 1'b0);

    // Reset after 20 bits of a symbol, then a fresh symbol: only the fresh one appears.
    mon_sel = 0;
    randomBits(20, x);
    base = got_bit.size();
    applyStimulus(0, x, 0, edges);
    doReset(1);
    randomBits(NC[0], b);
    interleave(0, b, x);
    applyStimulus(0, x, 0, edges);
    waitOutputs(base, NC[0]);
    checkOutput("abort_then_fresh", base, b, NC[0], edges[NC[0] - 1] + 1, 1'b1);

    // Reset during drain of an all-ones symbol: outputs drop next cycle, rest never emitted.
    mon_sel = 0;
    x = {};
    for (int i = 0; i < NC[0]; i++) x.push_back(1'b1);
    base = got_bit.size();
    applyStimulus(0, x, 0, edges);
    t = 0;
    while ((got_bit.size() - base) < 10 && t < TIMEOUT) begin
      @(negedge Clk);
      #1;
      t++;
    end
    Reset = 1'b1;
    cnt   = got_bit.size() - base;
    check("drain_reset bits_before_reset", cnt, 10);
    @(negedge Clk);
    #1;
    check("drain_reset out_valid_zero", int'(dval[0] === 1'b0), 1);
    check("drain_reset out_zero", int'(dout[0] === 1'b0), 1);
    check("drain_reset sym_last_zero", int'(dlast[0] === 1'b0), 1);
    Reset = 1'b0;
    repeat (60) @(negedge Clk);
    #1;
    check("drain_reset no_late_bits", got_bit.size() - base, cnt);

    // Idle outputs stayed zero and unused instances stayed quiet throughout.
    check("idle_output_nonzero", idle_bad - idle0, 0);
    check("stray_valid", stray - stray0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
